// File: rtl/riscv_pkg.sv
// Shared types and helpers for the riscv load/store path: access-size encoding,
// LSU FSM states, byte-enable patterns and alignment helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        MASK_X = 2'd0,
        MASK_B = 2'd1,
        MASK_H = 2'd2
    } MASK_SEL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } LSU_STATE;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    function automatic logic size_is_valid(input MASK_SEL size);
        case (size)
            MASK_X, MASK_B, MASK_H: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input MASK_SEL size, input logic [1:0] off);
        case (size)
            MASK_H:  return off[0];
            MASK_X:  return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Lane offset with the illegal low bits dropped, so a misaligned access lands on its natural boundary.
    function automatic logic [1:0] align_off(input MASK_SEL size, input logic [1:0] off);
        case (size)
            MASK_H:  return {off[1], 1'b0};
            MASK_X:  return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load-lane extraction: shifts the returned word down by the byte
// offset and sign- or zero-extends the byte/halfword result.
module riscv_load_align
    import riscv_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic [WORD_LENGTH-1:0] i_rdata,
    input  logic [1:0]             i_off,
    input  MASK_SEL                i_size,
    input  logic                   i_unsigned,
    output logic [WORD_LENGTH-1:0] o_result
);

    logic [WORD_LENGTH-1:0] w_word;
    logic                   w_sign_b;
    logic                   w_sign_h;

    // Extract the addressed lane and extend it to the full word.
    always_comb begin
        w_word   = i_rdata >> {i_off, 3'b000};
        w_sign_b = ~i_unsigned & w_word[7];
        w_sign_h = ~i_unsigned & w_word[15];
        case (i_size)
            MASK_B:  o_result = {{(WORD_LENGTH-8){w_sign_b}}, w_word[7:0]};
            MASK_H:  o_result = {{(WORD_LENGTH-16){w_sign_h}}, w_word[15:0]};
            MASK_X:  o_result = w_word;
            default: o_result = {WORD_LENGTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: aligns store data, drives a valid/ready word bus and returns
// extended load data with a one-cycle strobe. Optional macro RISCV_LSU_MISALIGN_TRAP_EN
// adds rsp_err and turns misaligned accesses into bus-less error responses.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WORD_LENGTH-1:0] req_addr,
    input  logic [WORD_LENGTH-1:0] req_wdata,
    input  MASK_SEL                req_size,
    input  logic                   req_unsigned,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_we,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic [3:0]             mem_be,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    input  logic                   mem_rvalid,
    input  logic [WORD_LENGTH-1:0] mem_rdata,
    output logic                   rsp_valid,
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    output logic                   rsp_err,
`endif
    output logic [WORD_LENGTH-1:0] rsp_rdata
);

    LSU_STATE               r_state;
    logic                   r_req_ready;
    logic                   r_mem_valid;
    logic                   r_mem_we;
    logic [WORD_LENGTH-1:0] r_mem_addr;
    logic [3:0]             r_mem_be;
    logic [WORD_LENGTH-1:0] r_mem_wdata;
    logic                   r_rsp_valid;
    logic [WORD_LENGTH-1:0] r_rsp_rdata;
    logic                   r_rsp_err;
    logic [1:0]             r_off;
    MASK_SEL                r_size;
    logic                   r_unsigned;

    logic [1:0]             w_off;
    logic [3:0]             w_be;
    logic                   w_misalign;
    logic                   w_skip_bus;
    logic [WORD_LENGTH-1:0] w_load_result;

    // Request decode: lane offset, byte enables and whether the bus is bypassed.
    always_comb begin
        w_off      = align_off(req_size, req_addr[1:0]);
        w_misalign = is_misaligned(req_size, req_addr[1:0]);
        case (req_size)
            MASK_B:  w_be = BE_B << w_off;
            MASK_H:  w_be = BE_H << w_off;
            MASK_X:  w_be = BE_W;
            default: w_be = 4'b0000;
        endcase
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
        w_skip_bus = !size_is_valid(req_size) || w_misalign;
`else
        w_skip_bus = !size_is_valid(req_size);
`endif
    end

    riscv_load_align #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_load_align (
        .i_rdata    (mem_rdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load_result)
    );

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {WORD_LENGTH{1'b0}};
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= {WORD_LENGTH{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {WORD_LENGTH{1'b0}};
            r_rsp_err   <= 1'b0;
            r_off       <= 2'b00;
            r_size      <= MASK_X;
            r_unsigned  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_off       <= w_off;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_mem_we    <= req_we;
                        r_mem_addr  <= {req_addr[WORD_LENGTH-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= req_wdata << {w_off, 3'b000};
                        if (w_skip_bus) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= {WORD_LENGTH{1'b0}};
                            r_rsp_err   <= w_misalign;
                            r_state     <= RESP;
                        end else begin
                            r_mem_valid <= 1'b1;
                            r_state     <= REQ;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_mem_we) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= {WORD_LENGTH{1'b0}};
                            r_state     <= RESP;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else begin
                        r_state <= REQ;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_result;
                        r_state     <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_valid <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    assign rsp_err   = r_rsp_err;
`else
    logic w_unused_err;
    assign w_unused_err = r_rsp_err;
`endif

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit sitting directly downstream of the store-data mask stage (riscv_mask1).
- Accepts one memory request per transaction from the execute stage: address, masked rs2 store data, access size (MASK_SEL) and load signedness.
- Aligns store data and generates byte enables for a word-addressed data bus, driving a valid/ready request channel.
- For loads, extracts and sign/zero-extends the returned lane and hands the result back with a one-cycle response strobe.
- Stalls the pipeline (req_ready low) while a transaction is in flight.

Parameters:
WORD_LENGTH, 32, data/address width; only 32 is supported (4 byte lanes).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  execute stage presents a request
req_ready  out  1  unit idle and can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  WORD_LENGTH  byte address
req_wdata  in  WORD_LENGTH  store data, already masked by riscv_mask1 (lane 0 aligned)
req_size  in  MASK_SEL  MASK_B / MASK_H / MASK_X (word)
req_unsigned  in  1  1 = zero-extend load (LBU/LHU)
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accepts request
mem_we  out  1  bus write
mem_addr  out  WORD_LENGTH  word-aligned address (bits [1:0] = 0)
mem_be  out  4  byte enables
mem_wdata  out  WORD_LENGTH  lane-shifted store data
mem_rvalid  in  1  read data valid
mem_rdata  in  WORD_LENGTH  read word
rsp_valid  out  1  one-cycle completion strobe
rsp_rdata  out  WORD_LENGTH  extended load result; 0 for stores

Behaviour:
- One clock (clk). Reset rst is synchronous, active-high. On reset: state IDLE and all outputs 0, except req_ready = 1. Reset mid-transaction abandons the transaction, so mem_valid is low after that edge.
- States:
  - IDLE: req_ready = 1. Accept on req_valid & req_ready: capture all req_* fields, go to REQ. Inputs are ignored outside acceptance.
  - REQ: mem_valid = 1, with mem_* held stable until mem_ready. On handshake: store → RESP, load → WAIT.
  - WAIT: on mem_rvalid, register the extracted result → RESP. mem_rvalid outside WAIT is ignored.
  - RESP: rsp_valid = 1 for exactly one cycle → IDLE.
- Minimum latency with mem_ready and mem_rvalid both at their earliest:
  - Store: accept at cycle 0, rsp_valid at cycle 2.
  - Load: rsp_valid at cycle 3.
- Alignment, with off = addr[1:0]:
  - B: be = 4'b0001 << off.
  - H: be = 4'b0011 << off.
  - X: be = 4'b1111.
  - mem_wdata = wdata << 8*off.
  - mem_addr = {addr[31:2], 2'b00}.
- Load extraction: word = mem_rdata >> 8*off.
  - B: byte [7:0].
  - H: half [15:0].
  - X: full word.
  - B and H are sign-extended unless req_unsigned, then zero-extended.
- Misalignment (H with addr[0] = 1, or X with addr[1:0] != 0): handling is set by the macro below.
- Invalid req_size encoding: no bus transaction, straight to RESP with rsp_rdata = 0.
- A back-to-back request is accepted in the IDLE cycle immediately following RESP.

Optional Feature:
Macro RISCV_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - A misaligned request skips the bus: IDLE → RESP, with rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - rsp_err = 0 on all other responses.
- Undefined:
  - No rsp_err port.
  - The offending low address bits are forced to alignment: H uses off = {addr[1], 0}, X uses off = 0.
  - The transaction then proceeds normally.

Decomposition:
- Shared package riscv_pkg holds:
  - MASK_SEL enum (MASK_X, MASK_B, MASK_H).
  - LSU_STATE enum (IDLE, REQ, WAIT, RESP).
  - Byte-enable constants BE_B = 4'b0001, BE_H = 4'b0011, BE_W = 4'b1111.
- One combinational sub-module, riscv_load_align: given rdata, off, size and unsigned, it produces the extended result. It is used in the WAIT state and unit-tested on its own.

Test Plan:
1. Store byte: addr 0x103, size B, wdata 0x000000AB, mem_ready immediate → mem_addr 0x100, be 4'b1000, mem_wdata 0xAB000000, rsp_valid at cycle 2, rsp_rdata 0.
2. Signed and unsigned halfword loads: addr 0x202, size H, mem_rdata 0x8001_1234, rvalid 3 cycles late.
   - Signed → rsp_rdata 0xFFFF8001.
   - Repeated with req_unsigned = 1 → 0x00008001.
   - req_ready stays low throughout.
3. Bus stall: mem_ready held low 5 cycles on a word store to 0x40 → mem_valid, mem_addr, be 4'b1111 and wdata stay stable; exactly one rsp_valid.
4. Misaligned word load at 0x13:
   - With macro → no mem_valid, rsp_valid + rsp_err one cycle after acceptance.
   - Without macro → mem_addr 0x10, be 4'b1111, full-word result.
5. Reset asserted in WAIT → next cycle: IDLE, req_ready 1, mem_valid 0, rsp_valid 0. A late mem_rvalid produces no response.
6. Back-to-back load then store, req_valid held high → second request accepted the cycle after the first rsp_valid; responses in order.
